frame_param_scheduler: RTL
==========================

Name: frame_param_scheduler

Overview:
- Sits between the UART input assembler (IA) and the vertex-setup (VS) / raster datapath.
- Holds the 61-byte scene-parameter image in a shadow bank (written byte-wise by IA) and an active bank (driven to VS).
- Schedules shadow→active commits only inside vertical blanking, then kicks VS with a one-cycle `pc_data_ready` and waits for VS completion.
- Result: the raster never sees a half-updated triangle set mid-frame.

Parameters:
- NUM_BYTES, 61, bytes in the parameter image (index 0..NUM_BYTES-1; 60 = render_mode).
- V_ACTIVE, 480, first non-visible line; commit window is `y >= V_ACTIVE`.
- VS_TIMEOUT, 4096, max cycles to wait for `vs_done` after a kick.
- TMO_W, 13, width of the timeout counter; must hold VS_TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  IA byte-write strobe (IA `update_reg`)
- wr_idx  in  6  byte index
- wr_data  in  8  byte value
- pkt_done  in  1  one-cycle pulse, IA packet complete (IA `pc_ready`)
- y  in  10  current VGA line
- vs_done  in  1  one-cycle pulse, VS finished setup
- active_regs  out  8*NUM_BYTES  active bank; byte k at [8k+7:8k]
- pc_data_ready  out  1  one-cycle kick to VS
- busy  out  1  high in COMMIT, KICK or BUSY
- pending  out  1  committed-not-yet packet waiting
- vs_timeout_err  out  1  sticky; set on timeout

Behaviour:
- Reset: shadow and active banks all zero; pending=0; pc_data_ready=0; busy=0; vs_timeout_err=0; state IDLE. Reset mid-operation aborts any state, discarding shadow contents.
- Shadow writes are accepted in every state. On `wr_en`, `shadow[wr_idx] <= wr_data` next edge. If `wr_idx >= NUM_BYTES`, the write is ignored with no side effect.
- pending flag: set the cycle after `pkt_done`. Cleared in COMMIT unless `pkt_done` is high in that same COMMIT cycle, in which case it stays 1.
- A second `pkt_done` while pending=1 is an overrun: pending stays 1 and the latest shadow data wins.
- vblank is defined as `(y >= V_ACTIVE)`, evaluated combinationally from the input `y`.

State machine:
- IDLE: go to COMMIT when `pending && vblank`.
- COMMIT (1 cycle): `active <= shadow` (whole bank, same edge). A `wr_en` in this cycle lands in shadow only, so active gets the pre-write value. Next state: KICK.
- KICK (1 cycle): `pc_data_ready = 1` (registered, high exactly during KICK). Clear the timeout counter. Next state: BUSY.
- BUSY: on `vs_done`, go to IDLE. When the counter reaches VS_TIMEOUT-1 without `vs_done`, set `vs_timeout_err` and go to IDLE. A `vs_done` in IDLE/COMMIT/KICK is ignored.

Latency and window rules:
- Latency: first cycle with `y >= V_ACTIVE` while IDLE and pending → `pc_data_ready` high 2 cycles later; active bank is updated one cycle before `pc_data_ready`.
- `pkt_done` during BUSY: pending set; the commit waits for IDLE and a vblank, and may fall in the same vblank if still inside the window.
- vblank ending during BUSY does not abort.
- No commit ever starts when `y < V_ACTIVE`. An already-entered COMMIT/KICK completes even if `y` wraps to 0.

Optional Feature:
- Macro FRAME_PARAM_STATS_EN.
- When defined: adds outputs `commit_cnt [15:0]` (increments in each COMMIT) and `overrun_cnt [15:0]` (increments on each overrun `pkt_done`). Both are wrap-around, reset to 0.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package `tiniest_gpu_pkg`:
  - NUM_BYTES
  - byte-index constants (e.g. IDX_X_V0_L=0, IDX_NX_L=18, IDX_LIGHT_X_L=24, IDX_VP00_L=30, IDX_X_V3_L=54, IDX_RENDER_MODE=60)
  - V_ACTIVE
  - state enum {IDLE, COMMIT, KICK, BUSY}
- One sub-module `param_bank`: shadow/active storage, byte write port and bulk copy strobe. The FSM, pending flag and timeout stay in the top.

Test Plan:
- Reset, then write `idx0=0x34`, `idx1=0x12`, pulse `pkt_done` at y=100 → `active_regs[15:0]` stays 0x0000 and no kick until y=480; `pc_data_ready` high exactly 2 cycles after y first reads 480, `active_regs[15:0]=0x1234` in that cycle.
- Write `idx60=0xA5` and `idx63=0xFF`, commit → `active_regs[487:480]=0xA5`; nothing else changes.
- Two `pkt_done` pulses before vblank, with `idx0=0x11` then `idx0=0x22` → single kick, `active[7:0]=0x22`; with FRAME_PARAM_STATS_EN, `overrun_cnt=1` and `commit_cnt=1`.
- After a kick, hold `vs_done=0` → `vs_timeout_err=1` after 4096 cycles, state IDLE, `busy=0`; a later commit still works.
- `pkt_done` while BUSY, `vs_done` at y=500 → second kick 3 cycles after `vs_done` (IDLE, COMMIT, KICK) in the same vblank.
- Assert reset during BUSY with pending=1 → next cycle all outputs 0, active bank 0, no kick at the following vblank.

Source files
------------

// File: rtl/tiniest_gpu_pkg.sv
// Shared constants and types for the scene-parameter path between the UART
// input assembler and the vertex-setup / raster datapath.
package tiniest_gpu_pkg;

    localparam int NUM_BYTES  = 61;
    localparam int IDX_W      = 6;
    localparam int Y_W        = 10;
    localparam int VS_TIMEOUT = 4096;
    localparam int TMO_W      = 13;

    localparam logic [Y_W-1:0] V_ACTIVE = 10'd480;

    // Byte offsets of the main fields inside the parameter image
    localparam logic [IDX_W-1:0] IDX_X_V0_L      = 6'd0;
    localparam logic [IDX_W-1:0] IDX_NX_L        = 6'd18;
    localparam logic [IDX_W-1:0] IDX_LIGHT_X_L   = 6'd24;
    localparam logic [IDX_W-1:0] IDX_VP00_L      = 6'd30;
    localparam logic [IDX_W-1:0] IDX_X_V3_L      = 6'd54;
    localparam logic [IDX_W-1:0] IDX_RENDER_MODE = 6'd60;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_KICK   = 2'd2,
        ST_BUSY   = 2'd3
    } state_e;

    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return int'(idx) < NUM_BYTES;
    endfunction

endpackage

// File: rtl/frame_param_scheduler_param_bank.sv
// Shadow/active storage for the parameter image: byte-wise shadow writes and
// a whole-bank shadow->active copy strobe.
module param_bank
    import tiniest_gpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [IDX_W-1:0]       wr_idx_i,
    input  logic [7:0]             wr_data_i,
    input  logic                   copy_i,
    output logic [8*NUM_BYTES-1:0] active_o
);

    logic [7:0] shadow_q [NUM_BYTES];
    logic [7:0] active_q [NUM_BYTES];

    // A write coinciding with copy_i lands in shadow only; active takes the old byte
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (wr_en_i && idx_valid(wr_idx_i)) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
            if (copy_i) begin
                active_q <= shadow_q;
            end
        end
    end

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_pack
        assign active_o[8*k +: 8] = active_q[k];
    end

endmodule

// File: rtl/frame_param_scheduler.sv
// Commits the shadow parameter image to the active bank only during vertical
// blanking, kicks vertex setup and waits for it. Optional: FRAME_PARAM_STATS_EN.
module frame_param_scheduler
    import tiniest_gpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [7:0]             wr_data,
    input  logic                   pkt_done,
    input  logic [Y_W-1:0]         y,
    input  logic                   vs_done,
    output logic [8*NUM_BYTES-1:0] active_regs,
    output logic                   pc_data_ready,
    output logic                   busy,
    output logic                   pending,
    output logic                   vs_timeout_err
`ifdef FRAME_PARAM_STATS_EN
   ,output logic [15:0]            commit_cnt,
    output logic [15:0]            overrun_cnt
`endif
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(VS_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             kick_q, kick_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             vblank;
    logic             commit;
    logic             overrun;

    assign vblank  = (y >= V_ACTIVE);
    assign commit  = (state_q == ST_COMMIT);
    // In COMMIT the pending packet is being consumed, so a new one is not an overrun
    assign overrun = pkt_done && pending_q && !commit;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | pkt_done;
        kick_d    = 1'b0;
        err_d     = err_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q && vblank) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                pending_d = pkt_done;
                kick_d    = 1'b1;
                state_d   = ST_KICK;
            end
            ST_KICK: begin
                tmo_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (vs_done) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            kick_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            kick_q    <= kick_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    param_bank u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .copy_i    (commit),
        .active_o  (active_regs)
    );

    assign pc_data_ready  = kick_q;
    assign busy           = (state_q != ST_IDLE);
    assign pending        = pending_q;
    assign vs_timeout_err = err_q;

`ifdef FRAME_PARAM_STATS_EN
    logic [15:0] commit_cnt_q;
    logic [15:0] overrun_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt_q  <= '0;
            overrun_cnt_q <= '0;
        end else begin
            if (commit) begin
                commit_cnt_q <= commit_cnt_q + 16'd1;
            end
            if (overrun) begin
                overrun_cnt_q <= overrun_cnt_q + 16'd1;
            end
        end
    end

    assign commit_cnt  = commit_cnt_q;
    assign overrun_cnt = overrun_cnt_q;
`endif

endmodule
